instr_queue: RTL and testbench

Instruction queue between the fetcher and the decode stage. It buffers the instructions the fetcher returns, each tagged with its PC, in a small circular FIFO, and presents them to decode with a valid/ready handshake. When a control-transfer instruction leaves the queue, the block asserts a branch hold toward the fetcher, waits for the branch resolution, and flushes all younger entries if the branch is taken.

---
 rtl/instr_queue.sv | 145 ++++++++++++++
 tb/tb_instr_queue.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_queue.sv
// Instruction queue between fetch and decode.
// Circular FIFO of {instr, pc} pairs with a valid/ready interface on both
// sides. Popping a control-transfer instruction raises a branch hold until
// the CU resolves it. A taken branch flushes every younger entry.
module instr_queue #(
  parameter int bits  = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [bits-1:0]          in_instr,
  input  logic [bits-1:0]          in_pc,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [bits-1:0]          out_instr,
  output logic [bits-1:0]          out_pc,
  input  logic                     out_ready,
  output logic                     br_hold,
  input  logic                     resolve,
  input  logic                     taken,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic {
    RUN,
    WAIT_RES
  } state_e;

  typedef struct packed {
    logic [bits-1:0] instr;
    logic [bits-1:0] pc;
  } entry_t;

  state_e           state_q, state_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  entry_t           mem_q [DEPTH];
  entry_t           head;

  logic push;
  logic pop;
  logic flush_now;
  logic is_cti;

  // Handshake qualifiers and the head-of-queue view presented to decode.
  always_comb begin
    head      = mem_q[rd_ptr_q];
    out_instr = head.instr;
    out_pc    = head.pc;
    count     = count_q;
    push      = in_valid && in_ready;
    pop       = out_valid && out_ready;
  end

  // Control-transfer decode on the opcode of the head instruction.
  always_comb begin
    // NOTE: every signal written in a combinational block gets a default
    // first, so no path leaves it unassigned and no latch is inferred.
    is_cti = 1'b0;
    unique case (out_instr[6:0])
      7'b1100011,
      7'b1101111,
      7'b1100111: is_cti = 1'b1;
      default:    is_cti = 1'b0;
    endcase
  end

  // Branch FSM: state register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Branch FSM: next-state logic. Resolve outside WAIT_RES is ignored.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:      if (pop && is_cti) state_d = WAIT_RES;
      WAIT_RES: if (resolve)       state_d = RUN;
      default:  state_d = RUN;
    endcase
  end

  // Branch FSM: outputs. in_ready never looks at out_ready, only at
  // registered state plus resolve/taken.
  always_comb begin
    br_hold   = (state_q == WAIT_RES);
    flush_now = br_hold && resolve && taken;
    in_ready  = (count_q != FULL_CNT) && !flush_now;
    out_valid = (count_q != '0) && !br_hold;
  end

  // Pointer and occupancy next-state; a flush overrides any movement.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (flush_now) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage, written on an accepted push.
  always_ff @(posedge clk) begin
    // NOTE: the storage array has no reset; occupancy and pointers decide
    // what is valid, so stale contents are never observed.
    if (push) begin
      mem_q[wr_ptr_q] <= '{instr: in_instr, pc: in_pc};
    end
  end

endmodule

// File: tb/tb_instr_queue.sv
// Scoreboard bench for instr_queue: stimulus pushes expected {instr, pc}
// pairs, a negedge monitor pops and compares on every decode handshake.
module tb_instr_queue;

  localparam int BITS  = 32;
  localparam int DEPTH = 4;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] BEQ  = 32'h0020_8463;
  localparam logic [31:0] JAL  = 32'h0000_006F;
  localparam logic [31:0] JALR = 32'h0000_8067;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } entry_t;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     in_valid;
  logic [BITS-1:0]          in_instr;
  logic [BITS-1:0]          in_pc;
  logic                     in_ready;
  logic                     out_valid;
  logic [BITS-1:0]          out_instr;
  logic [BITS-1:0]          out_pc;
  logic                     out_ready;
  logic                     br_hold;
  logic                     resolve;
  logic                     taken;
  logic [$clog2(DEPTH):0]   count;

  entry_t exp_q[$];
  entry_t mon_e;
  int     checks = 0;
  int     errors = 0;

  instr_queue #(.bits(BITS), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_instr  (in_instr),
    .in_pc     (in_pc),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_instr (out_instr),
    .out_pc    (out_pc),
    .out_ready (out_ready),
    .br_hold   (br_hold),
    .resolve   (resolve),
    .taken     (taken),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One-cycle push attempt; acc is the hand-derived acceptance.
  task automatic do_push(input logic [31:0] instr, input logic [31:0] pc, input logic acc);
    in_valid = 1'b1;
    in_instr = instr;
    in_pc    = pc;
    if (acc) exp_q.push_back({instr, pc});
    @(negedge clk);
    check("in_ready_on_push", 32'(in_ready), 32'(acc));
    step();
    in_valid = 1'b0;
  endtask

  // Monitor: a handshake seen at the negedge completes at the next posedge.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pop_pc", out_pc, 32'hFFFF_FFFF);
      end else begin
        mon_e = exp_q.pop_front();
        check("pop_pc", out_pc, mon_e.pc);
        check("pop_instr", out_instr, mon_e.instr);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_instr  = '0;
    in_pc     = '0;
    out_ready = 1'b0;
    resolve   = 1'b0;
    taken     = 1'b0;
    step();
    step();
    @(negedge clk);
    check("rst_count", 32'(count), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_br_hold", 32'(br_hold), 32'd0);
    step();
    rst = 1'b0;

    // Fill with decode stalled, try one push into a full queue, then drain.
    for (int i = 0; i < 4; i++) do_push(NOP, 32'(4 * i), 1'b1);
    @(negedge clk);
    check("full_count", 32'(count), 32'd4);
    check("full_in_ready", 32'(in_ready), 32'd0);
    step();
    do_push(NOP, 32'h10, 1'b0);
    @(negedge clk);
    check("full_count_after_reject", 32'(count), 32'd4);
    step();
    out_ready = 1'b1;
    repeat (4) step();
    @(negedge clk);
    check("drain_count", 32'(count), 32'd0);
    check("drain_out_valid", 32'(out_valid), 32'd0);
    step();

    // Streaming across the pointer wrap, one push and one pop per cycle.
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_instr = NOP;
      in_pc    = 32'h100 + 32'(4 * i);
      exp_q.push_back({NOP, 32'h100 + 32'(4 * i)});
      @(negedge clk);
      check("wrap_count_le1", 32'(count <= 1), 32'd1);
      step();
    end
    in_valid = 1'b0;
    step();
    @(negedge clk);
    check("wrap_count_end", 32'(count), 32'd0);
    step();

    // Not-taken branch.
    out_ready = 1'b0;
    do_push(BEQ, 32'h10, 1'b1);
    do_push(NOP, 32'h14, 1'b1);
    do_push(NOP, 32'h18, 1'b1);
    out_ready = 1'b1;
    @(negedge clk);
    check("nt_head_pc", out_pc, 32'h10);
    step();
    @(negedge clk);
    check("nt_br_hold", 32'(br_hold), 32'd1);
    check("nt_out_valid_held", 32'(out_valid), 32'd0);
    check("nt_count", 32'(count), 32'd2);
    step();
    resolve = 1'b1;
    taken   = 1'b0;
    @(negedge clk);
    check("nt_hold_until_edge", 32'(br_hold), 32'd1);
    check("nt_in_ready_in_hold", 32'(in_ready), 32'd1);
    step();
    resolve = 1'b0;
    @(negedge clk);
    check("nt_release", 32'(br_hold), 32'd0);
    check("nt_next_valid", 32'(out_valid), 32'd1);
    check("nt_next_pc", out_pc, 32'h14);
    step();
    step();
    @(negedge clk);
    check("nt_count_end", 32'(count), 32'd0);
    step();

    // Taken branch with a colliding push in the resolve cycle.
    out_ready = 1'b0;
    do_push(BEQ, 32'h20, 1'b1);
    do_push(NOP, 32'h24, 1'b1);
    do_push(NOP, 32'h28, 1'b1);
    out_ready = 1'b1;
    step();
    resolve  = 1'b1;
    taken    = 1'b1;
    in_valid = 1'b1;
    in_instr = NOP;
    in_pc    = 32'h2C;
    @(negedge clk);
    check("tk_in_ready_flush", 32'(in_ready), 32'd0);
    check("tk_br_hold", 32'(br_hold), 32'd1);
    check("tk_count_before", 32'(count), 32'd2);
    exp_q.delete();
    step();
    resolve  = 1'b0;
    taken    = 1'b0;
    in_pc    = 32'h40;
    exp_q.push_back({NOP, 32'h40});
    @(negedge clk);
    check("tk_count_flushed", 32'(count), 32'd0);
    check("tk_in_ready_after", 32'(in_ready), 32'd1);
    check("tk_br_hold_after", 32'(br_hold), 32'd0);
    check("tk_out_valid_after", 32'(out_valid), 32'd0);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    check("tk_redirect_pc", out_pc, 32'h40);
    check("tk_redirect_valid", 32'(out_valid), 32'd1);
    step();

    // JAL then JALR each raise the hold.
    do_push(JAL, 32'h80, 1'b1);
    @(negedge clk);
    check("jal_valid", 32'(out_valid), 32'd1);
    step();
    @(negedge clk);
    check("jal_br_hold", 32'(br_hold), 32'd1);
    step();
    resolve = 1'b1;
    taken   = 1'b1;
    step();
    resolve = 1'b0;
    taken   = 1'b0;
    @(negedge clk);
    check("jal_release", 32'(br_hold), 32'd0);
    step();
    do_push(JALR, 32'h200, 1'b1);
    @(negedge clk);
    check("jalr_valid", 32'(out_valid), 32'd1);
    step();
    @(negedge clk);
    check("jalr_br_hold", 32'(br_hold), 32'd1);
    step();
    resolve = 1'b1;
    step();
    resolve = 1'b0;
    @(negedge clk);
    check("jalr_release", 32'(br_hold), 32'd0);
    step();

    // Reset while three entries are queued behind an outstanding branch.
    out_ready = 1'b0;
    do_push(BEQ, 32'h300, 1'b1);
    do_push(NOP, 32'h304, 1'b1);
    do_push(NOP, 32'h308, 1'b1);
    do_push(NOP, 32'h30C, 1'b1);
    out_ready = 1'b1;
    step();
    @(negedge clk);
    check("mid_count", 32'(count), 32'd3);
    check("mid_br_hold", 32'(br_hold), 32'd1);
    step();
    rst = 1'b1;
    exp_q.delete();
    step();
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_count", 32'(count), 32'd0);
    check("mid_rst_br_hold", 32'(br_hold), 32'd0);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    step();

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
